getir_hizalayici: RTL and testbench

Fetch-2 realignment and predecode stage. It accepts 32-bit words from instruction memory and packs them into a 3-halfword parcel buffer, so that both 16-bit and 32-bit instructions are extracted, including ones that straddle a word boundary. Each instruction is predecoded and presented, registered, with its address to the branch predictor and decode. The `is_*` outputs are exactly the predecode inputs the predictor consumes.

---
 rtl/getir_hizalayici.sv | 166 ++++++++++++++++
 tb/tb_getir_hizalayici.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/getir_hizalayici.sv
// Fetch-2 realignment and predecode: packs memory words into a parcel buffer and emits aligned instructions.
// Define COMPRESSED_EN to enable 16-bit (C-extension) realignment and predecode; otherwise every word is one 32-bit instruction.
module getir_hizalayici #(
  parameter logic [31:0] RESET_ADRES = 32'h0000_0000
) (
  input  logic        clk_g,
  input  logic        rst_g,
  input  logic        i_bellek_gecerli,
  input  logic [31:0] i_bellek_adres,
  input  logic [31:0] i_bellek_veri,
  output logic        o_bellek_hazir,
  input  logic        i_yonlendir,
  input  logic [31:0] i_yonlendir_adres,
  output logic        o_gecerli,
  input  logic        i_hazir,
  output logic [31:0] o_buyruk,
  output logic [31:0] o_buyruk_adresi,
  output logic        o_is_branch,
  output logic        o_is_jal,
  output logic        o_is_jalr,
  output logic        o_is_jr,
  output logic        o_is_j,
  output logic        o_is_comp
);

`ifdef COMPRESSED_EN
  localparam int NP = 3;
`else
  localparam int NP = 2;
`endif
  localparam int W = 16 * NP;

  logic [W-1:0] r_tampon;
  logic [1:0]   r_sayac;
  logic [31:0]  r_bas_adres;
  logic [31:0]  r_beklenen;
  logic         r_yarim_atla;

  logic [15:0]  w_p0;
  logic [15:0]  w_p1;
  logic         w_bas_comp;
  logic         w_bas_tam;
  logic         w_yukle;
  logic         w_ekle;
  logic [1:0]   w_pop;
  logic [1:0]   w_kalan;
  logic [1:0]   w_ek_say;
  logic [1:0]   w_yeni_sayac;
  logic [31:0]  w_ek_veri;
  logic [31:0]  w_ek_adres;
  logic [W-1:0] w_yeni_tampon;
  logic [31:0]  w_buyruk;
  logic [5:0]   w_bayrak;
  logic         w_unused;

  assign w_p0     = r_tampon[15:0];
  assign w_p1     = r_tampon[31:16];
  assign w_unused = ^i_yonlendir_adres[1:0];

`ifdef COMPRESSED_EN
  assign o_bellek_hazir = (r_sayac <= 2'd1);
  assign w_bas_comp     = (w_p0[1:0] != 2'b11);
`else
  assign o_bellek_hazir = (r_sayac == 2'd0);
  assign w_bas_comp     = 1'b0;
`endif

  assign w_bas_tam = w_bas_comp ? (r_sayac >= 2'd1) : (r_sayac >= 2'd2);
  assign w_yukle   = (!o_gecerli || i_hazir) && w_bas_tam;
  assign w_pop     = w_yukle ? (w_bas_comp ? 2'd1 : 2'd2) : 2'd0;
  assign w_ekle    = i_bellek_gecerli && o_bellek_hazir && (i_bellek_adres == r_beklenen);
  assign w_kalan   = r_sayac - w_pop;

  // Pop the emitted parcels first, then append the new word behind whatever remains.
  always_comb begin
    w_ek_veri  = i_bellek_veri;
    w_ek_say   = 2'd2;
    w_ek_adres = i_bellek_adres;
    if (r_yarim_atla) begin
      w_ek_veri  = {16'h0000, i_bellek_veri[31:16]};
      w_ek_say   = 2'd1;
      w_ek_adres = i_bellek_adres + 32'd2;
    end
    w_yeni_tampon = r_tampon >> {w_pop, 4'b0000};
    w_yeni_sayac  = w_kalan;
    if (w_ekle) begin
      w_yeni_tampon = w_yeni_tampon | (W'(w_ek_veri) << {w_kalan, 4'b0000});
      w_yeni_sayac  = w_kalan + w_ek_say;
    end
  end

  // Flag order: {branch, jal, jalr, jr, j, comp}
  always_comb begin
    w_bayrak = 6'b000000;
    w_buyruk = {w_p1, w_p0};
    if (w_bas_comp) begin
      w_buyruk    = {16'h0000, w_p0};
      w_bayrak[0] = 1'b1;
`ifdef COMPRESSED_EN
      if (w_p0[1:0] == 2'b01) begin
        case (w_p0[15:13])
          3'b101:        w_bayrak[1] = 1'b1;
          3'b001:        w_bayrak[4] = 1'b1;
          3'b110, 3'b111: w_bayrak[5] = 1'b1;
          default: ;
        endcase
      end
      if (w_p0[1:0] == 2'b10 && w_p0[6:2] == 5'd0 && w_p0[11:7] != 5'd0) begin
        if (w_p0[15:12] == 4'b1000) w_bayrak[2] = 1'b1;
        if (w_p0[15:12] == 4'b1001) w_bayrak[3] = 1'b1;
      end
`endif
    end else begin
      case (w_p0[6:0])
        7'b1100011: w_bayrak[5] = 1'b1;
        7'b1101111: w_bayrak[4] = 1'b1;
        7'b1100111: w_bayrak[3] = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_g or negedge rst_g) begin
    if (!rst_g) begin
      r_tampon        <= '0;
      r_sayac         <= 2'd0;
      r_bas_adres     <= RESET_ADRES;
      r_beklenen      <= RESET_ADRES;
      r_yarim_atla    <= 1'b0;
      o_gecerli       <= 1'b0;
      o_buyruk        <= 32'd0;
      o_buyruk_adresi <= 32'd0;
      {o_is_branch, o_is_jal, o_is_jalr, o_is_jr, o_is_j, o_is_comp} <= 6'b000000;
    end else if (i_yonlendir) begin
      // Clearing the buffer keeps unused parcel slots zero so appends can simply OR in.
      r_tampon   <= '0;
      r_sayac    <= 2'd0;
      r_beklenen <= {i_yonlendir_adres[31:2], 2'b00};
`ifdef COMPRESSED_EN
      r_yarim_atla <= i_yonlendir_adres[1];
`else
      r_yarim_atla <= 1'b0;
`endif
      o_gecerli <= 1'b0;
      {o_is_branch, o_is_jal, o_is_jalr, o_is_jr, o_is_j, o_is_comp} <= 6'b000000;
    end else begin
      r_tampon <= w_yeni_tampon;
      r_sayac  <= w_yeni_sayac;
      if (w_ekle) begin
        r_beklenen   <= r_beklenen + 32'd4;
        r_yarim_atla <= 1'b0;
      end
      if (w_ekle && w_kalan == 2'd0) r_bas_adres <= w_ek_adres;
      else                           r_bas_adres <= r_bas_adres + {29'd0, w_pop, 1'b0};
      if (w_yukle) begin
        o_gecerli       <= 1'b1;
        o_buyruk        <= w_buyruk;
        o_buyruk_adresi <= r_bas_adres;
        {o_is_branch, o_is_jal, o_is_jalr, o_is_jr, o_is_j, o_is_comp} <= w_bayrak;
      end else if (!o_gecerli || i_hazir) begin
        o_gecerli <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_getir_hizalayici.sv
// Directed bench for getir_hizalayici: a table of per-cycle vectors plus hand-written redirect/stall/reset sequences.
// Compressed-only sequences are included when COMPRESSED_EN is defined.
module tb_getir_hizalayici;

  logic        clk_g;
  logic        rst_g;
  logic        i_bellek_gecerli;
  logic [31:0] i_bellek_adres;
  logic [31:0] i_bellek_veri;
  logic        o_bellek_hazir;
  logic        i_yonlendir;
  logic [31:0] i_yonlendir_adres;
  logic        o_gecerli;
  logic        i_hazir;
  logic [31:0] o_buyruk;
  logic [31:0] o_buyruk_adresi;
  logic        o_is_branch, o_is_jal, o_is_jalr, o_is_jr, o_is_j, o_is_comp;

  int hata;
  int toplam;

  // Flag order: {branch, jal, jalr, jr, j, comp}
  localparam logic [5:0] F_YOK = 6'b000000;
  localparam logic [5:0] F_BR  = 6'b100000;
  localparam logic [5:0] F_JAL = 6'b010000;
  localparam logic [5:0] F_JR2 = 6'b001000;

  typedef struct {
    logic        v;
    logic [31:0] a;
    logic [31:0] d;
    logic        hz;
    logic        eg;
    logic        ebh;
    logic [31:0] eb;
    logic [31:0] ea;
    logic [5:0]  ef;
  } vec_t;

  vec_t tablo [14];

  getir_hizalayici #(.RESET_ADRES(32'h0000_0100)) dut (
    .clk_g            (clk_g),
    .rst_g            (rst_g),
    .i_bellek_gecerli (i_bellek_gecerli),
    .i_bellek_adres   (i_bellek_adres),
    .i_bellek_veri    (i_bellek_veri),
    .o_bellek_hazir   (o_bellek_hazir),
    .i_yonlendir      (i_yonlendir),
    .i_yonlendir_adres(i_yonlendir_adres),
    .o_gecerli        (o_gecerli),
    .i_hazir          (i_hazir),
    .o_buyruk         (o_buyruk),
    .o_buyruk_adresi  (o_buyruk_adresi),
    .o_is_branch      (o_is_branch),
    .o_is_jal         (o_is_jal),
    .o_is_jalr        (o_is_jalr),
    .o_is_jr          (o_is_jr),
    .o_is_j           (o_is_j),
    .o_is_comp        (o_is_comp)
  );

  initial clk_g = 1'b0;
  always #5 clk_g = ~clk_g;

  task automatic applyStimulus(input logic v, input logic [31:0] a, input logic [31:0] d,
                               input logic hz, input logic yon, input logic [31:0] ya);
    i_bellek_gecerli  = v;
    i_bellek_adres    = a;
    i_bellek_veri     = d;
    i_hazir           = hz;
    i_yonlendir       = yon;
    i_yonlendir_adres = ya;
    @(posedge clk_g);
    #1;
  endtask

  task automatic checkOutput(input string ad, input logic eg, input logic ebh, input logic veri_kontrol,
                             input logic [31:0] eb, input logic [31:0] ea, input logic [5:0] ef);
    logic [5:0] bayrak;
    bayrak = {o_is_branch, o_is_jal, o_is_jalr, o_is_jr, o_is_j, o_is_comp};
    toplam++;
    if (o_gecerli !== eg) begin
      hata++;
      $display("[TB] FAIL %s o_gecerli: got %b want %b", ad, o_gecerli, eg);
    end
    toplam++;
    if (o_bellek_hazir !== ebh) begin
      hata++;
      $display("[TB] FAIL %s o_bellek_hazir: got %b want %b", ad, o_bellek_hazir, ebh);
    end
    if (veri_kontrol) begin
      toplam++;
      if (o_buyruk !== eb) begin
        hata++;
        $display("[TB] FAIL %s o_buyruk: got %h want %h", ad, o_buyruk, eb);
      end
      toplam++;
      if (o_buyruk_adresi !== ea) begin
        hata++;
        $display("[TB] FAIL %s o_buyruk_adresi: got %h want %h", ad, o_buyruk_adresi, ea);
      end
      toplam++;
      if (bayrak !== ef) begin
        hata++;
        $display("[TB] FAIL %s flags: got %b want %b", ad, bayrak, ef);
      end
    end
  endtask

  initial begin
    hata   = 0;
    toplam = 0;
    rst_g  = 1'b0;
    i_bellek_gecerli  = 1'b0;
    i_bellek_adres    = 32'd0;
    i_bellek_veri     = 32'd0;
    i_hazir           = 1'b1;
    i_yonlendir       = 1'b0;
    i_yonlendir_adres = 32'd0;

    // Single 32-bit words only, so these rows hold with or without COMPRESSED_EN.
    tablo[0]  = '{1'b1, 32'h100, 32'h00A00093, 1'b1, 1'b0, 1'b0, 32'h0,        32'h0,   F_YOK};
    tablo[1]  = '{1'b1, 32'h104, 32'hFE0098E3, 1'b1, 1'b1, 1'b1, 32'h00A00093, 32'h100, F_YOK};
    tablo[2]  = '{1'b1, 32'h104, 32'hFE0098E3, 1'b1, 1'b0, 1'b0, 32'h0,        32'h0,   F_YOK};
    tablo[3]  = '{1'b0, 32'h0,   32'h0,        1'b1, 1'b1, 1'b1, 32'hFE0098E3, 32'h104, F_BR};
    tablo[4]  = '{1'b0, 32'h0,   32'h0,        1'b1, 1'b0, 1'b1, 32'h0,        32'h0,   F_YOK};
    tablo[5]  = '{1'b1, 32'h108, 32'h0000006F, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,   F_YOK};
    tablo[6]  = '{1'b1, 32'h10C, 32'h00008067, 1'b0, 1'b1, 1'b1, 32'h0000006F, 32'h108, F_JAL};
    tablo[7]  = '{1'b1, 32'h10C, 32'h00008067, 1'b0, 1'b1, 1'b0, 32'h0000006F, 32'h108, F_JAL};
    tablo[8]  = '{1'b0, 32'h0,   32'h0,        1'b0, 1'b1, 1'b0, 32'h0000006F, 32'h108, F_JAL};
    tablo[9]  = '{1'b0, 32'h0,   32'h0,        1'b1, 1'b1, 1'b1, 32'h00008067, 32'h10C, F_JR2};
    tablo[10] = '{1'b1, 32'h100, 32'h12345678, 1'b1, 1'b0, 1'b1, 32'h0,        32'h0,   F_YOK};
    tablo[11] = '{1'b1, 32'h110, 32'h00000013, 1'b1, 1'b0, 1'b0, 32'h0,        32'h0,   F_YOK};
    tablo[12] = '{1'b0, 32'h0,   32'h0,        1'b1, 1'b1, 1'b1, 32'h00000013, 32'h110, F_YOK};
    tablo[13] = '{1'b0, 32'h0,   32'h0,        1'b1, 1'b0, 1'b1, 32'h0,        32'h0,   F_YOK};

    #12;
    checkOutput("reset", 1'b0, 1'b1, 1'b1, 32'h0, 32'h0, F_YOK);
    rst_g = 1'b1;

    for (int i = 0; i < 14; i++) begin
      applyStimulus(tablo[i].v, tablo[i].a, tablo[i].d, tablo[i].hz, 1'b0, 32'h0);
      checkOutput($sformatf("tablo%0d", i), tablo[i].eg, tablo[i].ebh, tablo[i].eg,
                  tablo[i].eb, tablo[i].ea, tablo[i].ef);
    end

    // Redirect while an instruction is pending; the word offered in the redirect cycle must be dropped.
    applyStimulus(1'b1, 32'h114, 32'h00A00093, 1'b0, 1'b0, 32'h0);
    checkOutput("yon_r0", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, F_YOK);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    checkOutput("yon_r1", 1'b1, 1'b1, 1'b1, 32'h00A00093, 32'h114, F_YOK);
    applyStimulus(1'b1, 32'h118, 32'hDEADBEEF, 1'b0, 1'b1, 32'h204);
    checkOutput("yon_r2", 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, F_YOK);
    applyStimulus(1'b1, 32'h204, 32'h00000063, 1'b1, 1'b0, 32'h0);
    checkOutput("yon_r3", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, F_YOK);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    checkOutput("yon_r4", 1'b1, 1'b1, 1'b1, 32'h00000063, 32'h204, F_BR);

    // Stale response after a redirect to 0x300.
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h300);
    checkOutput("bayat_s0", 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, F_YOK);
    applyStimulus(1'b1, 32'h100, 32'h00A00093, 1'b1, 1'b0, 32'h0);
    checkOutput("bayat_s1", 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, F_YOK);
    applyStimulus(1'b1, 32'h300, 32'h0000006F, 1'b1, 1'b0, 32'h0);
    checkOutput("bayat_s2", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, F_YOK);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    checkOutput("bayat_s3", 1'b1, 1'b1, 1'b1, 32'h0000006F, 32'h300, F_JAL);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    checkOutput("bayat_s4", 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, F_YOK);

`ifndef COMPRESSED_EN
    // Without C support, address bit 1 is ignored and a 0x..01 low parcel is still part of a 32-bit word.
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h206);
    checkOutput("tam_d0", 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, F_YOK);
    applyStimulus(1'b1, 32'h204, 32'h0093A001, 1'b1, 1'b0, 32'h0);
    checkOutput("tam_d1", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, F_YOK);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    checkOutput("tam_d2", 1'b1, 1'b1, 1'b1, 32'h0093A001, 32'h204, F_YOK);
`else
    // C.J followed by a 32-bit instruction straddling into the next word.
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h0);
    checkOutput("c_c0", 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, F_YOK);
    applyStimulus(1'b1, 32'h0, 32'h0093A001, 1'b1, 1'b0, 32'h0);
    checkOutput("c_c1", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, F_YOK);
    applyStimulus(1'b1, 32'h4, 32'h02000000, 1'b1, 1'b0, 32'h0);
    checkOutput("c_c2", 1'b1, 1'b1, 1'b1, 32'h0000A001, 32'h0, 6'b000011);
    applyStimulus(1'b1, 32'h4, 32'h02000000, 1'b1, 1'b0, 32'h0);
    checkOutput("c_c3", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, F_YOK);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    checkOutput("c_c4", 1'b1, 1'b1, 1'b1, 32'h00000093, 32'h2, F_YOK);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    checkOutput("c_c5", 1'b1, 1'b1, 1'b1, 32'h00000200, 32'h6, 6'b000001);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    checkOutput("c_c6", 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, F_YOK);

    // Fill to three parcels behind a stalled output, then drain.
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h10);
    checkOutput("c_t0", 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, F_YOK);
    applyStimulus(1'b1, 32'h10, 32'h00010001, 1'b0, 1'b0, 32'h0);
    checkOutput("c_t1", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, F_YOK);
    applyStimulus(1'b1, 32'h14, 32'h00090005, 1'b0, 1'b0, 32'h0);
    checkOutput("c_t2", 1'b1, 1'b1, 1'b1, 32'h00000001, 32'h10, 6'b000001);
    applyStimulus(1'b1, 32'h14, 32'h00090005, 1'b0, 1'b0, 32'h0);
    checkOutput("c_t3", 1'b1, 1'b0, 1'b1, 32'h00000001, 32'h10, 6'b000001);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
      checkOutput($sformatf("c_durak%0d", k), 1'b1, 1'b0, 1'b1, 32'h00000001, 32'h10, 6'b000001);
    end
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    checkOutput("c_t9", 1'b1, 1'b0, 1'b1, 32'h00000001, 32'h12, 6'b000001);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    checkOutput("c_t10", 1'b1, 1'b1, 1'b1, 32'h00000005, 32'h14, 6'b000001);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    checkOutput("c_t11", 1'b1, 1'b1, 1'b1, 32'h00000009, 32'h16, 6'b000001);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    checkOutput("c_t12", 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, F_YOK);

    // Redirect into the upper half of a word: only C.JR survives.
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h206);
    checkOutput("c_u0", 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, F_YOK);
    applyStimulus(1'b1, 32'h204, 32'h80820001, 1'b1, 1'b0, 32'h0);
    checkOutput("c_u1", 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, F_YOK);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    checkOutput("c_u2", 1'b1, 1'b1, 1'b1, 32'h00008082, 32'h206, 6'b000101);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    checkOutput("c_u3", 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, F_YOK);
`endif

    // Asynchronous reset mid-stream, then restart from RESET_ADRES.
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h400);
    checkOutput("rst_m0", 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, F_YOK);
    applyStimulus(1'b1, 32'h400, 32'h00A00093, 1'b0, 1'b0, 32'h0);
    checkOutput("rst_m1", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, F_YOK);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    checkOutput("rst_m2", 1'b1, 1'b1, 1'b1, 32'h00A00093, 32'h400, F_YOK);
    #2;
    rst_g = 1'b0;
    #1;
    checkOutput("rst_async", 1'b0, 1'b1, 1'b1, 32'h0, 32'h0, F_YOK);
    #2;
    rst_g = 1'b1;
    applyStimulus(1'b1, 32'h400, 32'h00A00093, 1'b1, 1'b0, 32'h0);
    checkOutput("rst_m3", 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, F_YOK);
    applyStimulus(1'b1, 32'h100, 32'h0000006F, 1'b1, 1'b0, 32'h0);
    checkOutput("rst_m4", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, F_YOK);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    checkOutput("rst_m5", 1'b1, 1'b1, 1'b1, 32'h0000006F, 32'h100, F_JAL);

    $display("Result: errors=%0d of %0d checks", hata, toplam);
    $finish;
  end

endmodule
